sonos_pulse_sequencer: RTL and testbench

// Digital pulse sequencer feeding the SONOS flash cell array.

---
 rtl/sonos_pulse_sequencer_pkg.sv | 34 +++
 rtl/sonos_sync_2ff.sv | 30 +++
 rtl/sonos_pulse_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sonos_pulse_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sonos_pulse_sequencer_pkg.sv
// Shared definitions for the SONOS pulse sequencer.
// Contents:
//   op_t     - command opcodes as seen on cmd_op
//   state_t  - sequencer FSM state encodings
//   CNT_W    - width of the shared phase down-counter
//   PCNT_W   - width of the saturating pulse counter
//   eff_width() - maps a requested pulse width of 0 onto 1
package sonos_pulse_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_PROG  = 2'd2,
    OP_ERASE = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int CNT_W  = 8;
  localparam int PCNT_W = 16;

  // A zero-width pulse would leave the cell untouched while still being
  // counted, so the smallest pulse is one cycle.
  function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w);
    return (w == '0) ? CNT_W'(1) : w;
  endfunction

endpackage

// File: rtl/sonos_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (the sense
// comparator). Both flops reset to 0.
// Ports:
//   clk    in  tile clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronised output (two clock latency)
module sonos_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/sonos_pulse_sequencer.sv
// Pulse sequencer for the SONOS flash cell array. Accepts READ / PROGRAM /
// ERASE / NOP commands, drives one-hot analog enables with cycle-exact
// setup, pulse and guard windows, and returns a one-word response.
// Ports:
//   clk, rst_n             tile clock, asynchronous active-low reset
//   ena                    tile enable, gates acceptance only
//   cmd_valid/cmd_ready    command handshake (ready is combinational)
//   cmd_op/addr/width      opcode, target cell, pulse width (0 -> 1)
//   abort                  safe termination of the running operation
//   clr_count              synchronous clear of pulse_count
//   sense_in               asynchronous sense comparator output
//   cell_addr              registered cell address to the array
//   rd_en/pgm_en/ers_en    registered one-hot analog enables
//   busy                   high whenever the FSM is not idle
//   rsp_valid/data/err     one-cycle response strobe and payload
//   pulse_count            saturating PROGRAM+ERASE pulse count
module sonos_pulse_sequencer #(
  parameter int ADDR_W    = 3,
  parameter int SETUP_CYC = 4,
  parameter int GUARD_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_width,
  input  logic              abort,
  input  logic              clr_count,
  input  logic              sense_in,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              rd_en,
  output logic              pgm_en,
  output logic              ers_en,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_data,
  output logic              rsp_err,
  output logic [15:0]       pulse_count
);

  import sonos_pulse_sequencer_pkg::*;

  // Counter preloads: each phase counts down to 0 and then leaves.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  op_t                 op_reg, op_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [CNT_W-1:0]    width_reg, width_next;
  logic                aborted_reg, aborted_next;
  logic                sense_bit_reg, sense_bit_next;
  logic [PCNT_W-1:0]   count_reg, count_next;
  logic                rd_en_reg, rd_en_next;
  logic                pgm_en_reg, pgm_en_next;
  logic                ers_en_reg, ers_en_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic                rsp_data_reg, rsp_data_next;
  logic                rsp_err_reg, rsp_err_next;

  logic                sense_sync;
  logic                accept;
  logic                pulse_entry;

  sonos_sync_2ff u_sense_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sense_in),
    .q     (sense_sync)
  );

  assign cmd_ready = (state_reg == ST_IDLE) & ena;
  assign accept    = cmd_valid & cmd_ready;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      op_reg        <= OP_NOP;
      addr_reg      <= '0;
      width_reg     <= '0;
      aborted_reg   <= 1'b0;
      sense_bit_reg <= 1'b0;
      count_reg     <= '0;
      rd_en_reg     <= 1'b0;
      pgm_en_reg    <= 1'b0;
      ers_en_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      width_reg     <= width_next;
      aborted_reg   <= aborted_next;
      sense_bit_reg <= sense_bit_next;
      count_reg     <= count_next;
      rd_en_reg     <= rd_en_next;
      pgm_en_reg    <= pgm_en_next;
      ers_en_reg    <= ers_en_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    width_next     = width_reg;
    aborted_next   = aborted_reg;
    sense_bit_next = sense_bit_reg;
    pulse_entry    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next        = op_t'(cmd_op);
          addr_next      = cmd_addr;
          width_next     = eff_width(cmd_width);
          aborted_next   = 1'b0;
          sense_bit_next = 1'b0;
          if (op_t'(cmd_op) == OP_NOP) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SETUP;
            cnt_next   = SETUP_LOAD;
          end
        end
      end
      ST_SETUP: begin
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = ST_RECOVER;
          cnt_next     = GUARD_LOAD;
        end else if (cnt_reg == '0) begin
          state_next  = ST_PULSE;
          cnt_next    = width_reg - CNT_W'(1);
          pulse_entry = (op_reg == OP_PROG) || (op_reg == OP_ERASE);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = ST_RECOVER;
          cnt_next     = GUARD_LOAD;
        end else if (cnt_reg == '0) begin
          // Last pulse cycle: capture the sense bit for a READ.
          if (op_reg == OP_READ) sense_bit_next = sense_sync;
          state_next = ST_RECOVER;
          cnt_next   = GUARD_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        // The guard always runs to completion; abort only flags the response.
        if (abort) aborted_next = 1'b1;
        if (cnt_reg == '0) state_next = ST_DONE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    count_next = count_reg;
    if (clr_count)                             count_next = '0;
    else if (pulse_entry && (count_reg != '1)) count_next = count_reg + PCNT_W'(1);
  end

  // Output decode: registered outputs follow the state being entered, so
  // they line up exactly with the state they describe.
  always_comb begin
    rd_en_next     = (state_next == ST_PULSE) && (op_next == OP_READ);
    pgm_en_next    = (state_next == ST_PULSE) && (op_next == OP_PROG);
    ers_en_next    = (state_next == ST_PULSE) && (op_next == OP_ERASE);
    rsp_valid_next = (state_next == ST_DONE);
    rsp_err_next   = (state_next == ST_DONE) && aborted_next;
    rsp_data_next  = (state_next == ST_DONE) && !aborted_next &&
                     (op_next == OP_READ) && sense_bit_next;
  end

  assign cell_addr   = addr_reg;
  assign rd_en       = rd_en_reg;
  assign pgm_en      = pgm_en_reg;
  assign ers_en      = ers_en_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign pulse_count = count_reg;

endmodule

// File: tb/tb_sonos_pulse_sequencer.sv
// Directed, table-driven bench for sonos_pulse_sequencer (S=4, G=8).
// Cycle numbering: cycle 0 is the cycle in which the command is accepted;
// outputs for cycle k are sampled on the falling edge after the k-th
// rising edge following acceptance.
module tb_sonos_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_addr = 3'd0;
  logic [7:0]  cmd_width = 8'd0;
  logic        abort = 1'b0;
  logic        clr_count = 1'b0;
  logic        sense_in = 1'b0;
  logic [2:0]  cell_addr;
  logic        rd_en, pgm_en, ers_en, busy;
  logic        rsp_valid, rsp_data, rsp_err;
  logic [15:0] pulse_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sonos_pulse_sequencer #(.ADDR_W(3), .SETUP_CYC(4), .GUARD_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_width(cmd_width), .abort(abort), .clr_count(clr_count),
    .sense_in(sense_in), .cell_addr(cell_addr), .rd_en(rd_en),
    .pgm_en(pgm_en), .ers_en(ers_en), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .pulse_count(pulse_count)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  addr;
    logic [7:0]  width;
    logic        sense;
    int          abort_cyc;   // 0 = no abort
    int          clr_cyc;     // 0 = no clear
    bit          ena_drop;    // drop ena from cycle 2 until the response
    int          en_sel;      // 0 rd, 1 pgm, 2 ers, 3 none
    int          exp_len;
    int          exp_first;
    int          exp_done;
    logic        exp_data;
    logic        exp_err;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   en_cnt[3];
    int   first_en;
    int   done_cyc;
    int   multi_en;
    int   cyc;
    logic got_data, got_err, busy1;
    logic [2:0] got_addr;
    string tag;
    tag = $sformatf("v%0d", idx);
    en_cnt = '{0, 0, 0};
    first_en = 0; done_cyc = 0; multi_en = 0;
    got_data = 1'b0; got_err = 1'b0; got_addr = 3'd0; busy1 = 1'b0;

    @(negedge clk);
    sense_in = v.sense;
    @(negedge clk);
    @(negedge clk);
    cmd_op = v.op; cmd_addr = v.addr; cmd_width = v.width; cmd_valid = 1'b1;
    chk({tag, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd0;
    cyc = 1;
    while (done_cyc == 0 && cyc < 200) begin
      if (cyc == 1) busy1 = busy;
      if (rd_en)  en_cnt[0]++;
      if (pgm_en) en_cnt[1]++;
      if (ers_en) en_cnt[2]++;
      if ((32'(rd_en) + 32'(pgm_en) + 32'(ers_en)) > 1) multi_en++;
      if ((rd_en || pgm_en || ers_en) && first_en == 0) first_en = cyc;
      if (rsp_valid) begin
        done_cyc = cyc; got_data = rsp_data; got_err = rsp_err; got_addr = cell_addr;
      end
      abort     = (cyc == v.abort_cyc);
      clr_count = (cyc == v.clr_cyc);
      ena       = !(v.ena_drop && cyc >= 2);
      if (done_cyc != 0) begin
        ena = 1'b1; abort = 1'b0; clr_count = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    abort = 1'b0; clr_count = 1'b0; ena = 1'b1;

    chk({tag, " busy_cycle1"}, {31'd0, busy1}, 32'd1);
    chk({tag, " done_cycle"}, done_cyc, v.exp_done);
    chk({tag, " rsp_data"}, {31'd0, got_data}, {31'd0, v.exp_data});
    chk({tag, " rsp_err"}, {31'd0, got_err}, {31'd0, v.exp_err});
    chk({tag, " cell_addr"}, {29'd0, got_addr}, {29'd0, v.addr});
    chk({tag, " onehot"}, multi_en, 0);
    chk({tag, " first_enable"}, first_en, v.exp_first);
    for (int e = 0; e < 3; e++)
      chk($sformatf("%s en%0d_len", tag, e), en_cnt[e], (e == v.en_sel) ? v.exp_len : 0);

    @(negedge clk);
    chk({tag, " rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " ready_after"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, " addr_held"}, {29'd0, cell_addr}, {29'd0, v.addr});
    chk({tag, " pulse_count"}, {16'd0, pulse_count}, {16'd0, v.exp_count});
    $display("vec %0d op=%0d addr=%0d width=%0d done@%0d data=%0b err=%0b count=%0h",
             idx, v.op, v.addr, v.width, done_cyc, got_data, got_err, pulse_count);
  endtask

  initial begin
    logic seen_bad;
    // op addr width sense abort clr ena_drop en_sel len first done data err count
    vecs[0]  = '{2'd1, 3'd5, 8'd3,  1'b1, 0, 0, 1'b0, 0, 3, 5, 16, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{2'd2, 3'd2, 8'd0,  1'b0, 0, 0, 1'b0, 1, 1, 5, 14, 1'b0, 1'b0, 16'd1};
    vecs[2]  = '{2'd3, 3'd7, 8'd2,  1'b1, 0, 0, 1'b1, 2, 2, 5, 15, 1'b0, 1'b0, 16'd2};
    vecs[3]  = '{2'd1, 3'd1, 8'd1,  1'b0, 0, 0, 1'b0, 0, 1, 5, 14, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{2'd0, 3'd3, 8'd9,  1'b1, 0, 0, 1'b0, 3, 0, 0, 1,  1'b0, 1'b0, 16'd2};
    vecs[5]  = '{2'd3, 3'd4, 8'd10, 1'b0, 6, 0, 1'b0, 2, 2, 5, 15, 1'b0, 1'b1, 16'd3};
    vecs[6]  = '{2'd1, 3'd6, 8'd4,  1'b1, 2, 0, 1'b0, 3, 0, 0, 11, 1'b0, 1'b1, 16'd3};
    vecs[7]  = '{2'd1, 3'd0, 8'd2,  1'b1, 9, 0, 1'b0, 0, 2, 5, 15, 1'b0, 1'b1, 16'd3};
    // Run after the counter is preloaded to FFFE.
    vecs[8]  = '{2'd2, 3'd0, 8'd1,  1'b0, 0, 0, 1'b0, 1, 1, 5, 14, 1'b0, 1'b0, 16'hFFFF};
    vecs[9]  = '{2'd2, 3'd1, 8'd1,  1'b0, 0, 0, 1'b0, 1, 1, 5, 14, 1'b0, 1'b0, 16'hFFFF};
    vecs[10] = '{2'd3, 3'd2, 8'd1,  1'b0, 0, 4, 1'b0, 2, 1, 5, 14, 1'b0, 1'b0, 16'd0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset enables", {29'd0, rd_en, pgm_en, ers_en}, 32'd0);
    chk("reset rsp", {29'd0, rsp_valid, rsp_data, rsp_err}, 32'd0);
    chk("reset cell_addr", {29'd0, cell_addr}, 32'd0);
    chk("reset pulse_count", {16'd0, pulse_count}, 32'd0);
    chk("reset ready_in_reset", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // cmd_valid held with ena low: never accepted.
    seen_bad = 1'b0;
    ena = 1'b0; cmd_op = 2'd1; cmd_addr = 3'd7; cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cmd_ready || busy || rd_en) seen_bad = 1'b1;
    end
    cmd_valid = 1'b0; cmd_op = 2'd0; ena = 1'b1;
    chk("ena_low never_accepted", {31'd0, seen_bad}, 32'd0);
    chk("ena_low addr_unchanged", {29'd0, cell_addr}, 32'd0);
    $display("ena-low hold: accepted=%0b", seen_bad);

    // Preload the pulse counter just below saturation.
    @(negedge clk);
    force dut.count_reg = 16'hFFFE;
    @(negedge clk);
    release dut.count_reg;
    @(negedge clk);
    chk("preload pulse_count", {16'd0, pulse_count}, 32'h0000FFFE);

    for (int i = 8; i < 11; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a PROGRAM pulse.
    @(negedge clk);
    cmd_op = 2'd2; cmd_addr = 3'd3; cmd_width = 8'd10; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd0;
    repeat (5) @(negedge clk);  // now at cycle 6, inside PULSE
    chk("rst mid-pulse pgm_en before", {31'd0, pgm_en}, 32'd1);
    chk("rst mid-pulse count before", {16'd0, pulse_count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid-pulse enables", {29'd0, rd_en, pgm_en, ers_en}, 32'd0);
    chk("rst mid-pulse busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst ready", {31'd0, cmd_ready}, 32'd1);
    chk("post-rst pulse_count", {16'd0, pulse_count}, 32'd0);
    chk("post-rst cell_addr", {29'd0, cell_addr}, 32'd0);
    $display("async reset mid-pulse: busy=%0b ready=%0b count=%0h", busy, cmd_ready, pulse_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
